hfrv_trace_buffer: RTL and testbench
====================================

Name: hfrv_trace_buffer

Overview:
- Synthesizable, parametrised multi-channel trace capture buffer for the HF-RISCV core.
- Taps snapshot-style events (retired instruction, data access, UART byte, ...) on independent channels and merges them round-robin into one circular buffer, tagged with channel id and optional timestamp.
- A valid/ready drain port lets the verification environment or a debug UART bridge read entries out, with stop-on-full or overwrite-oldest policy.

Parameters:
- DATA_W, 32, payload width per channel
- CHANNELS, 4, number of capture channels (1..8)
- DEPTH, 16, buffer entries; power of two, >= 2
- TS_W, 16, timestamp width (used only with TRACE_TS_EN)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  synchronous active-low reset
- cap_valid  in  CHANNELS  per-channel event strobe, one cycle per event
- cap_data  in  CHANNELS*DATA_W  channel c payload at [c*DATA_W +: DATA_W]
- arm  in  1  pulse: IDLE/STOP -> RUN
- stop  in  1  pulse: RUN -> STOP
- clear  in  1  pulse: flush buffer, counters, sticky flags; go IDLE
- mode  in  1  0 = stop-on-full, 1 = overwrite oldest
- out_valid  out  1  head entry available
- out_ready  in  1  drain accepts head
- out_data  out  DATA_W  head payload
- out_chan  out  max(1,$clog2(CHANNELS))  head channel id
- out_ts  out  TS_W  head timestamp
- count  out  $clog2(DEPTH+1)  entries held
- state  out  2  00 IDLE, 01 RUN, 10 STOP
- overflow  out  1  sticky: an entry was overwritten
- drop_cnt  out  16  saturating count of lost events

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, pointers/count 0, out_valid 0, out_data/out_chan/out_ts 0, overflow 0, drop_cnt 0, all skid registers empty, round-robin pointer 0, timestamp 0. Reset mid-capture discards everything; no partial drain.
- Per-channel skid (1 entry), RUN only: cap_valid[c] with skid empty -> load {data, ts}. With skid full -> event dropped, drop_cnt+1. Outside RUN cap_valid is ignored; no drop counted.
- Arbiter: each cycle picks at most one full skid, round-robin starting at the channel after the last grant, and writes it to the buffer. A skid freed this cycle may reload the same cycle.
- Write rules:
  - Not full -> write, count+1.
  - Full, mode=1 -> overwrite oldest, advance both pointers, overflow=1, count unchanged.
  - Full, mode=0 -> no write; state -> STOP next cycle; remaining skids are discarded at the STOP transition and each counts as one drop.
- Simultaneous write and pop: count unchanged. A write while full in mode=1 plus a pop in the same cycle is treated as a normal push+pop; overflow is not set.
- Pointers wrap modulo DEPTH.
- Latency: event at cycle N -> skid at N+1 -> buffer write at N+1 edge if granted -> out_valid=1 at N+2 when the buffer was empty. out_* registered and stable while out_valid && !out_ready.
- Drain works in every state. STOP keeps contents.
- FSM:
  - IDLE -arm-> RUN
  - RUN -stop or full(mode=0)-> STOP
  - STOP -arm-> RUN, contents retained
  - any -clear-> IDLE
  - Priority: clear > stop > arm. Clear empties the buffer and skids on the next edge, and out_valid drops.
- drop_cnt saturates at 16'hFFFF.

Optional Feature:
- TRACE_TS_EN defined: a free-running TS_W-bit counter, reset to 0, wrapping, is sampled into the skid at capture time and stored per entry; out_ts presents the head timestamp.
- Not defined: no counter and no timestamp storage; out_ts tied to 0.

Test Plan:
- Reset, arm, cap_valid[2] with 32'hDEADBEEF at cycle 10 -> out_valid at 12, out_data DEADBEEF, out_chan 2; with TRACE_TS_EN out_ts = value sampled at cycle 10.
- All 4 channels strobe the same cycle, out_ready=1 -> four entries drained in channel order 0,1,2,3, drop_cnt 0. The next simultaneous burst starts after the last grant.
- mode=0, DEPTH=16, 20 single-channel events spaced 2 cycles, no drain -> count 16, state STOP, first 16 payloads drained intact, later events not stored.
- mode=1, 20 events 0..19, no drain -> count 16, overflow 1, drain yields 4..19.
- Channel 1 strobes on consecutive cycles while channels 0 and 2 are held busy -> drop_cnt increments on each collision; drained order is correct.
- clear asserted together with arm and 5 entries held -> next cycle state IDLE, count 0, out_valid 0, drop_cnt 0; rst_n low mid-RUN gives the same result.

Source files
------------

// File: rtl/hfrv_trace_buffer.sv
// hfrv_trace_buffer: multi-channel trace capture buffer for the HF-RISCV core.
// Each channel owns a one-entry skid register. A round-robin arbiter merges the
// skids into a circular buffer, which is read out through a valid/ready drain port.
// When the buffer is full, mode=0 stops capture and mode=1 overwrites the oldest entry.
// Optional feature macro: TRACE_TS_EN adds a free-running timestamp stored with
// each entry. Without it, out_ts is tied to zero.

module hfrv_trace_buffer #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16,
    parameter int TS_W     = 16,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CNTW    = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CHANNELS-1:0]        cap_valid,
    input  logic [CHANNELS*DATA_W-1:0] cap_data,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       clear,
    input  logic                       mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [CW-1:0]              out_chan,
    output logic [TS_W-1:0]            out_ts,
    output logic [CNTW-1:0]            count,
    output logic [1:0]                 state,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_next_s;

    logic [CHANNELS-1:0] skid_full_r;
    logic [DATA_W-1:0]   skid_data_r [CHANNELS];
    logic [DATA_W-1:0]   mem_data_r  [DEPTH];
    logic [CW-1:0]       mem_chan_r  [DEPTH];

    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [CNTW-1:0]     count_r;
    logic [CW-1:0]       rr_ptr_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic [CW-1:0]       out_chan_r;
    logic                overflow_r;
    logic [15:0]         drop_cnt_r;

    logic                gnt_any_s;
    logic [CW-1:0]       gnt_idx_s;
    int                  idx_v;
    logic                run_s;
    logic                full_s;
    logic                pop_s;
    logic                blocked_s;
    logic                write_s;
    logic                overwrite_s;
    logic                leave_run_s;
    logic                bypass_s;
    logic [CHANNELS-1:0] freed_s;
    logic [CHANNELS-1:0] load_s;
    logic [CHANNELS-1:0] remain_s;
    logic [CHANNELS-1:0] skid_full_next_s;
    logic [4:0]          drop_inc_s;
    logic [16:0]         drop_sum_s;
    logic [15:0]         drop_next_s;
    logic [AW-1:0]       rd_next_s;
    logic [AW-1:0]       wr_next_s;
    logic [CNTW-1:0]     count_next_s;
    logic [CW-1:0]       rr_next_s;

    assign run_s       = (state_r == ST_RUN);
    assign full_s      = (count_r == CNTW'(DEPTH));
    assign pop_s       = out_valid_r && out_ready;
    // A full buffer only blocks in stop-on-full mode, and only when nothing leaves it this cycle.
    assign blocked_s   = gnt_any_s && full_s && !pop_s && !mode;
    assign write_s     = gnt_any_s && !blocked_s;
    assign overwrite_s = write_s && full_s && !pop_s;
    assign leave_run_s = run_s && (state_next_s != ST_RUN);
    // The entry written this cycle becomes the head when nothing older remains after the pop.
    assign bypass_s    = write_s && ((count_r == '0) || ((count_r == CNTW'(1'b1)) && pop_s));

    // Round-robin grant: first full skid at or after rr_ptr_r, wrapping.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        idx_v     = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx_v = int'(rr_ptr_r) + i;
            if (idx_v >= CHANNELS) begin
                idx_v = idx_v - CHANNELS;
            end else begin
                idx_v = idx_v;
            end
            if (!gnt_any_s && skid_full_r[idx_v]) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = CW'(idx_v);
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    // Next-state logic: clear beats stop, and stop beats arm.
    always_comb begin
        state_next_s = state_r;
        if (clear) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm) state_next_s = ST_RUN;
                    else     state_next_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (stop || blocked_s) state_next_s = ST_STOP;
                    else                   state_next_s = ST_RUN;
                end
                ST_STOP: begin
                    if (arm) state_next_s = ST_RUN;
                    else     state_next_s = ST_STOP;
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Skid occupancy and lost-event accounting. Collisions drop the new event.
    // Skids still occupied when capture leaves RUN are discarded and counted as drops.
    always_comb begin
        freed_s    = '0;
        load_s     = '0;
        remain_s   = '0;
        drop_inc_s = '0;
        if (write_s) begin
            freed_s[gnt_idx_s] = 1'b1;
        end else begin
            freed_s = '0;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (cap_valid[c] && run_s) begin
                if (skid_full_r[c] && !freed_s[c]) begin
                    drop_inc_s  = drop_inc_s + 5'd1;
                    remain_s[c] = 1'b1;
                end else begin
                    load_s[c]   = 1'b1;
                    remain_s[c] = 1'b1;
                end
            end else begin
                remain_s[c] = skid_full_r[c] && !freed_s[c];
            end
        end
        if (leave_run_s) begin
            for (int c = 0; c < CHANNELS; c++) begin
                drop_inc_s = drop_inc_s + {4'b0000, remain_s[c]};
            end
            skid_full_next_s = '0;
        end else begin
            skid_full_next_s = remain_s;
        end
        drop_sum_s = {1'b0, drop_cnt_r} + {12'b0, drop_inc_s};
        if (drop_sum_s > 17'h0FFFF) begin
            drop_next_s = 16'hFFFF;
        end else begin
            drop_next_s = drop_sum_s[15:0];
        end
    end

    // Pointer, occupancy and round-robin pointer updates.
    always_comb begin
        if (pop_s || overwrite_s) rd_next_s = rd_ptr_r + AW'(1'b1);
        else                      rd_next_s = rd_ptr_r;
        if (write_s) wr_next_s = wr_ptr_r + AW'(1'b1);
        else         wr_next_s = wr_ptr_r;
        if (write_s && !pop_s && !full_s) begin
            count_next_s = count_r + CNTW'(1'b1);
        end else if (!write_s && pop_s) begin
            count_next_s = count_r - CNTW'(1'b1);
        end else begin
            count_next_s = count_r;
        end
        if (!write_s) begin
            rr_next_s = rr_ptr_r;
        end else if (gnt_idx_s == CW'(CHANNELS - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = gnt_idx_s + CW'(1'b1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_next_s;
    end

    // Control registers: skid flags, pointers, count, sticky flags and drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            skid_full_r <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            rr_ptr_r    <= '0;
            overflow_r  <= 1'b0;
            drop_cnt_r  <= 16'h0000;
        end else begin
            skid_full_r <= skid_full_next_s;
            wr_ptr_r    <= wr_next_s;
            rd_ptr_r    <= rd_next_s;
            count_r     <= count_next_s;
            rr_ptr_r    <= rr_next_s;
            overflow_r  <= overflow_r | overwrite_s;
            drop_cnt_r  <= drop_next_s;
        end
    end

    // Datapath storage: skid payload capture and buffer writes. Validity comes from the flags.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (load_s[c]) skid_data_r[c] <= cap_data[c*DATA_W +: DATA_W];
        end
        if (write_s) begin
            mem_data_r[wr_ptr_r] <= skid_data_r[gnt_idx_s];
            mem_chan_r[wr_ptr_r] <= gnt_idx_s;
        end
    end

    // Registered head presentation. Held steady while the buffer's head is unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_chan_r  <= '0;
        end else if (count_next_s != '0) begin
            out_valid_r <= 1'b1;
            out_data_r  <= bypass_s ? skid_data_r[gnt_idx_s] : mem_data_r[rd_next_s];
            out_chan_r  <= bypass_s ? gnt_idx_s : mem_chan_r[rd_next_s];
        end else begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_chan_r  <= '0;
        end
    end

`ifdef TRACE_TS_EN
    logic [TS_W-1:0] ts_r;
    logic [TS_W-1:0] skid_ts_r [CHANNELS];
    logic [TS_W-1:0] mem_ts_r  [DEPTH];
    logic [TS_W-1:0] out_ts_r;

    // Free-running, wrapping timestamp.
    always_ff @(posedge clk) begin
        if (!rst_n) ts_r <= '0;
        else        ts_r <= ts_r + TS_W'(1'b1);
    end

    // Timestamp sampled at capture and carried along with the payload.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (load_s[c]) skid_ts_r[c] <= ts_r;
        end
        if (write_s) mem_ts_r[wr_ptr_r] <= skid_ts_r[gnt_idx_s];
    end

    // Registered head timestamp.
    always_ff @(posedge clk) begin
        if (!rst_n || clear)            out_ts_r <= '0;
        else if (count_next_s != '0)    out_ts_r <= bypass_s ? skid_ts_r[gnt_idx_s] : mem_ts_r[rd_next_s];
        else                            out_ts_r <= '0;
    end

    assign out_ts = out_ts_r;
`else
    assign out_ts = '0;
`endif

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;
    assign count     = count_r;
    assign state     = state_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_hfrv_trace_buffer.sv
// Scoreboard bench for hfrv_trace_buffer. Expected drain entries are queued as
// stimulus is issued, and a negedge monitor pops the queue on every accepted output.
module tb_hfrv_trace_buffer;
    localparam int DATA_W   = 32;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 16;
    localparam int TS_W     = 16;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [CHANNELS-1:0]        cap_valid;
    logic [CHANNELS*DATA_W-1:0] cap_data;
    logic                       arm, stop, clear, mode;
    logic                       out_valid, out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [1:0]                 out_chan;
    logic [TS_W-1:0]            out_ts;
    logic [4:0]                 count;
    logic [1:0]                 state;
    logic                       overflow;
    logic [15:0]                drop_cnt;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  chan;
        logic [15:0] ts;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        ts_ok;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] tb_ts;

    hfrv_trace_buffer #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .cap_data(cap_data),
        .arm(arm), .stop(stop), .clear(clear), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_chan(out_chan), .out_ts(out_ts), .count(count), .state(state),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference timestamp: starts at zero out of reset and advances once per clock.
    always @(posedge clk) begin
        if (!rst_n) tb_ts <= 16'd0;
        else        tb_ts <= tb_ts + 16'd1;
    end

    // Monitor: every accepted drain beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL drain_unexpected: got data %h chan %0d, expected no entry", out_data, out_chan);
            end else begin
                mon_e = exp_q.pop_front();
`ifdef TRACE_TS_EN
                ts_ok = (out_ts === mon_e.ts);
`else
                ts_ok = (out_ts === 16'd0);
`endif
                if (out_data !== mon_e.data || out_chan !== mon_e.chan || !ts_ok) begin
                    n_err++;
                    $display("FAIL drain_entry: got data %h chan %0d ts %h, expected data %h chan %0d ts %h",
                             out_data, out_chan, out_ts, mon_e.data, mon_e.chan, mon_e.ts);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cap_valid = '0; cap_data = '0;
        arm = 1'b0; stop = 1'b0; clear = 1'b0; mode = 1'b0; out_ready = 1'b0;
        steps(2);
        rst_n = 1'b1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    task automatic cap_one(input int ch, input logic [31:0] d, input bit push);
        cap_valid = '0;
        cap_valid[ch] = 1'b1;
        cap_data[ch*DATA_W +: DATA_W] = d;
        if (push) exp_q.push_back('{data: d, chan: 2'(ch), ts: tb_ts});
        step();
        cap_valid = '0;
    endtask

    task automatic burst4(input logic [31:0] base, input int first);
        cap_valid = 4'hF;
        for (int c = 0; c < CHANNELS; c++) cap_data[c*DATA_W +: DATA_W] = base + 32'(c);
        for (int k = 0; k < CHANNELS; k++) begin
            exp_q.push_back('{data: base + 32'((first + k) % CHANNELS), chan: 2'((first + k) % CHANNELS), ts: tb_ts});
        end
        step();
        cap_valid = '0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // Single event latency on channel 2
        pulse_arm();
        chk("arm_state", 32'(state), 32'd1);
        cap_one(2, 32'hDEADBEEF, 1'b1);
        chk("lat_n1_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_n2_valid", 32'(out_valid), 32'd1);
        chk("lat_n2_data", out_data, 32'hDEADBEEF);
        chk("lat_n2_chan", 32'(out_chan), 32'd2);
        step();
        chk("hold_data", out_data, 32'hDEADBEEF);
        out_ready = 1'b1;
        steps(3);
        chk("single_empty", 32'(count), 32'd0);

        // Stop, ignored capture in STOP, stop+arm priority
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop_state", 32'(state), 32'd2);
        cap_one(1, 32'h11111111, 1'b0);
        steps(3);
        chk("stop_ignore_count", 32'(count), 32'd0);
        chk("stop_ignore_drop", 32'(drop_cnt), 32'd0);
        pulse_arm();
        chk("rearm_state", 32'(state), 32'd1);
        stop = 1'b1; arm = 1'b1; step(); stop = 1'b0; arm = 1'b0;
        chk("stop_beats_arm", 32'(state), 32'd2);

        // Round-robin: simultaneous burst, single ch1, then a rotated burst
        do_reset();
        pulse_arm();
        out_ready = 1'b1;
        burst4(32'hA0000000, 0);
        steps(6);
        cap_one(1, 32'hB0000001, 1'b1);
        steps(4);
        burst4(32'hC0000000, 2);
        steps(6);
        chk("rr_drop", 32'(drop_cnt), 32'd0);
        chk("rr_count", 32'(count), 32'd0);

        // Stop-on-full: 20 events, first 16 retained
        do_reset();
        mode = 1'b0;
        pulse_arm();
        for (int k = 0; k < 20; k++) begin
            cap_one(0, 32'h50000000 + 32'(k), k < 16);
            step();
        end
        chk("sof_count", 32'(count), 32'd16);
        chk("sof_state", 32'(state), 32'd2);
        chk("sof_drop", 32'(drop_cnt), 32'd1);
        chk("sof_overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        steps(20);
        chk("sof_drained", 32'(count), 32'd0);
        chk("sof_state_kept", 32'(state), 32'd2);

        // Overwrite-oldest: 20 events, drain yields the last 16
        do_reset();
        mode = 1'b1;
        pulse_arm();
        for (int k = 0; k < 20; k++) begin
            cap_one(0, 32'(k), k >= 4);
            step();
        end
        chk("ovw_count", 32'(count), 32'd16);
        chk("ovw_overflow", 32'(overflow), 32'd1);
        chk("ovw_state", 32'(state), 32'd1);
        out_ready = 1'b1;
        steps(20);
        chk("ovw_drained", 32'(count), 32'd0);
        chk("ovw_sticky", 32'(overflow), 32'd1);

        // Collisions on channel 1 while channels 0 and 2 occupy the arbiter
        do_reset();
        mode = 1'b0;
        pulse_arm();
        out_ready = 1'b1;
        cap_valid = 4'b0111;
        cap_data[0*DATA_W +: DATA_W] = 32'hB0;
        cap_data[1*DATA_W +: DATA_W] = 32'hC0;
        cap_data[2*DATA_W +: DATA_W] = 32'hD0;
        exp_q.push_back('{data: 32'hB0, chan: 2'd0, ts: tb_ts});
        exp_q.push_back('{data: 32'hC0, chan: 2'd1, ts: tb_ts});
        exp_q.push_back('{data: 32'hD0, chan: 2'd2, ts: tb_ts});
        step();
        cap_one(1, 32'hC1, 1'b0);
        chk("col_drop1", 32'(drop_cnt), 32'd1);
        cap_one(1, 32'hC2, 1'b1);
        cap_one(1, 32'hC3, 1'b0);
        chk("col_drop2", 32'(drop_cnt), 32'd2);
        steps(8);
        chk("col_drop_final", 32'(drop_cnt), 32'd2);

        // Clear together with arm while holding 5 entries
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cap_one(3, 32'hE0 + 32'(k), 1'b0);
            step();
        end
        steps(2);
        chk("clr_pre_count", 32'(count), 32'd5);
        clear = 1'b1; arm = 1'b1; step(); clear = 1'b0; arm = 1'b0;
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        out_ready = 1'b1;
        steps(3);

        // Reset mid-RUN with 5 entries and a drop recorded
        out_ready = 1'b0;
        pulse_arm();
        cap_valid = 4'b0011;
        cap_data[0*DATA_W +: DATA_W] = 32'hF0;
        cap_data[1*DATA_W +: DATA_W] = 32'hF1;
        steps(2);
        cap_valid = '0;
        steps(3);
        cap_one(3, 32'hF3, 1'b0);
        step();
        cap_one(3, 32'hF4, 1'b0);
        steps(3);
        chk("rrun_pre_count", 32'(count), 32'd5);
        chk("rrun_pre_drop", 32'(drop_cnt), 32'd1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("rrun_state", 32'(state), 32'd0);
        chk("rrun_count", 32'(count), 32'd0);
        chk("rrun_valid", 32'(out_valid), 32'd0);
        chk("rrun_drop", 32'(drop_cnt), 32'd0);
        out_ready = 1'b1;
        steps(3);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
